// File: rtl/display_scan.sv
// display_scan: time-multiplexed driver for a 4-digit 7-segment display.
// Holds a 16-bit shadow copy of the hex value and scans the four digits in turn.
// Each digit slot opens with an anti-ghost blanking interval.
// Leading zeros can optionally be suppressed.
module display_scan #(
    parameter int CLK_DIV   = 50000,
    parameter int BLANK_CYC = 500
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [15:0] value,
    input  logic        blank_lz,
    output logic [3:0]  digit_nib,
    output logic [3:0]  dig_en_n,
    output logic        frame_done
);

    // Prescaler just wide enough for 0..CLK_DIV-1; a power-of-two CLK_DIV
    // therefore never needs to represent CLK_DIV itself.
    localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [PW-1:0] TERM      = PW'(CLK_DIV - 1);
    localparam logic [PW:0]   BLANK_LIM = (PW + 1)'(BLANK_CYC);

    logic [15:0]   shadow;
    logic [PW-1:0] presc;
    logic [1:0]    idx;
    logic          at_term;
    logic          blanking;
    logic [3:0]    lz_zero;

    assign at_term = (presc == TERM);

    // Capture the displayed value whenever load is strobed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow <= 16'h0000;
        end else if (load) begin
            shadow <= value;
        end
    end

    // Slot timer and digit index; a load never disturbs the scan position.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc <= '0;
            idx   <= 2'd0;
        end else if (at_term) begin
            presc <= '0;
            idx   <= idx + 2'd1;
        end else begin
            presc <= presc + PW'(1);
        end
    end

    // One-cycle frame pulse in the cycle after the scan wraps from digit 3 back to digit 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_done <= 1'b0;
        end else begin
            frame_done <= at_term && (idx == 2'd3);
        end
    end

    assign blanking = ({1'b0, presc} < BLANK_LIM);

    // lz_zero[k] is set when digits k..3 are all zero; digit 0 always stays visible.
    assign lz_zero[3] = (shadow[15:12] == 4'h0);
    assign lz_zero[2] = (shadow[15:8]  == 8'h00);
    assign lz_zero[1] = (shadow[15:4]  == 12'h000);
    assign lz_zero[0] = 1'b0;

    assign digit_nib = shadow[{idx, 2'b00} +: 4];

    // Enable at most the current digit, outside blanking and suppression;
    // reset forces all digits off even when there is no blanking interval.
    always_comb begin
        dig_en_n = 4'b1111;
        if (rst_n && !blanking && !(blank_lz && lz_zero[idx])) begin
            dig_en_n[idx] = 1'b0;
        end
    end

endmodule

// File: tb/tb_display_scan.sv
// tb_display_scan: directed, table-driven bench for display_scan.
// The main instance uses CLK_DIV=4, BLANK_CYC=1.
// A second instance uses CLK_DIV=2, BLANK_CYC=0 and checks fast scanning with no blanking.
module tb_display_scan;

    logic        clk;
    logic        rst_n;
    logic        load;
    logic [15:0] value;
    logic        blank_lz;
    logic [3:0]  digit_nib;
    logic [3:0]  dig_en_n;
    logic        frame_done;
    logic [3:0]  digit_nib2;
    logic [3:0]  dig_en_n2;
    logic        frame_done2;

    int assert_count = 0;
    int fail_count   = 0;
    int n            = 0;

    typedef struct packed {
        logic [15:0]     value;
        logic            lz;
        logic [3:0][3:0] nib;
        logic [3:0][3:0] en;
    } vec_t;

    vec_t vecs [6];

    display_scan #(.CLK_DIV(4), .BLANK_CYC(1)) dut (
        .clk(clk), .rst_n(rst_n), .load(load), .value(value), .blank_lz(blank_lz),
        .digit_nib(digit_nib), .dig_en_n(dig_en_n), .frame_done(frame_done)
    );

    display_scan #(.CLK_DIV(2), .BLANK_CYC(0)) dut2 (
        .clk(clk), .rst_n(rst_n), .load(load), .value(value), .blank_lz(blank_lz),
        .digit_nib(digit_nib2), .dig_en_n(dig_en_n2), .frame_done(frame_done2)
    );

    // Free-running 10-time-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_output(input string name, input logic [15:0] actual, input logic [15:0] expected);
        assert_count++;
        if (actual !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s at n=%0d: got %h, expected %h", name, n, actual, expected);
        end
    endtask

    // Reset both instances, release on a falling edge and capture v on the first rising edge.
    // Returns at the falling edge where n = 1.
    task automatic apply_stimulus(input logic [15:0] v, input logic lz);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n    = 1'b1;
        load     = 1'b1;
        value    = v;
        blank_lz = lz;
        n        = 0;
        @(negedge clk);
        load = 1'b0;
        n    = 1;
    endtask

    task automatic step_to(input int target);
        while (n < target) begin
            @(negedge clk);
            n++;
        end
    endtask

    logic [3:0][3:0] nib_1a3f;
    logic [3:0]      exp_en;
    int              slot;
    int              pos;

    initial begin
        rst_n    = 1'b0;
        load     = 1'b0;
        value    = 16'h0000;
        blank_lz = 1'b0;

        vecs[0] = '{16'h1A3F, 1'b0, {4'h1, 4'hA, 4'h3, 4'hF}, {4'b0111, 4'b1011, 4'b1101, 4'b1110}};
        vecs[1] = '{16'h0050, 1'b1, {4'h0, 4'h0, 4'h5, 4'h0}, {4'b1111, 4'b1111, 4'b1101, 4'b1110}};
        vecs[2] = '{16'h0000, 1'b1, {4'h0, 4'h0, 4'h0, 4'h0}, {4'b1111, 4'b1111, 4'b1111, 4'b1110}};
        vecs[3] = '{16'h0050, 1'b0, {4'h0, 4'h0, 4'h5, 4'h0}, {4'b0111, 4'b1011, 4'b1101, 4'b1110}};
        vecs[4] = '{16'h0F00, 1'b1, {4'h0, 4'hF, 4'h0, 4'h0}, {4'b1111, 4'b1011, 4'b1101, 4'b1110}};
        vecs[5] = '{16'h8000, 1'b1, {4'h8, 4'h0, 4'h0, 4'h0}, {4'b0111, 4'b1011, 4'b1101, 4'b1110}};
        nib_1a3f = {4'h1, 4'hA, 4'h3, 4'hF};

        // Reset state, both instances.
        #1;
        check_output("rst_nib", 16'(digit_nib), 16'h0);
        check_output("rst_en", 16'(dig_en_n), 16'hF);
        check_output("rst_fd", 16'(frame_done), 16'h0);
        check_output("rst_en2", 16'(dig_en_n2), 16'hF);
        check_output("rst_nib2", 16'(digit_nib2), 16'h0);

        // Table-driven scans: two full frames per vector.
        for (int vi = 0; vi < 6; vi++) begin
            apply_stimulus(vecs[vi].value, vecs[vi].lz);
            for (int k = 1; k <= 32; k++) begin
                slot   = (n / 4) % 4;
                pos    = n % 4;
                exp_en = (pos < 1) ? 4'b1111 : vecs[vi].en[slot];
                check_output("vec_nib", 16'(digit_nib), 16'(vecs[vi].nib[slot]));
                check_output("vec_en", 16'(dig_en_n), 16'(exp_en));
                check_output("vec_fd", 16'(frame_done), 16'((n % 16) == 0));
                @(negedge clk);
                n++;
            end
        end

        // CLK_DIV=2, BLANK_CYC=0: one-hot enable every cycle, index moves every 2 cycles.
        apply_stimulus(16'h1A3F, 1'b0);
        for (int k = 1; k <= 16; k++) begin
            slot   = (n / 2) % 4;
            exp_en = ~(4'b0001 << slot);
            check_output("fast_en", 16'(dig_en_n2), 16'(exp_en));
            check_output("fast_nib", 16'(digit_nib2), 16'(nib_1a3f[slot]));
            check_output("fast_fd", 16'(frame_done2), 16'((n % 8) == 0));
            @(negedge clk);
            n++;
        end

        // Mid-slot load: new data shows next cycle, slot timing unchanged.
        apply_stimulus(16'h1111, 1'b0);
        step_to(6);
        check_output("ml_en_pre", 16'(dig_en_n), 16'hD);
        check_output("ml_nib_pre", 16'(digit_nib), 16'h1);
        load  = 1'b1;
        value = 16'h2222;
        @(negedge clk);
        n++;
        load = 1'b0;
        check_output("ml_nib", 16'(digit_nib), 16'h2);
        check_output("ml_en", 16'(dig_en_n), 16'hD);
        @(negedge clk);
        n++;
        check_output("ml_blank", 16'(dig_en_n), 16'hF);
        @(negedge clk);
        n++;
        check_output("ml_next", 16'(dig_en_n), 16'hB);
        check_output("ml_nib2", 16'(digit_nib), 16'h2);

        // blank_lz takes effect combinationally.
        apply_stimulus(16'h0050, 1'b1);
        step_to(13);
        check_output("lz_on", 16'(dig_en_n), 16'hF);
        blank_lz = 1'b0;
        #1;
        check_output("lz_off", 16'(dig_en_n), 16'h7);
        blank_lz = 1'b1;
        #1;
        check_output("lz_on2", 16'(dig_en_n), 16'hF);

        // Asynchronous reset mid-slot with a pending load, then restart from digit 0.
        apply_stimulus(16'h1A3F, 1'b0);
        step_to(11);
        check_output("ar_pre_en", 16'(dig_en_n), 16'hB);
        check_output("ar_pre_nib", 16'(digit_nib), 16'hA);
        #2;
        rst_n = 1'b0;
        load  = 1'b1;
        value = 16'hFFFF;
        #1;
        check_output("ar_en", 16'(dig_en_n), 16'hF);
        check_output("ar_nib", 16'(digit_nib), 16'h0);
        check_output("ar_fd", 16'(frame_done), 16'h0);
        check_output("ar_en2", 16'(dig_en_n2), 16'hF);
        @(negedge clk);
        check_output("ar_hold_nib", 16'(digit_nib), 16'h0);
        check_output("ar_hold_en", 16'(dig_en_n), 16'hF);
        rst_n = 1'b1;
        load  = 1'b0;
        n     = 0;
        #1;
        check_output("ar_rel_en", 16'(dig_en_n), 16'hF);
        @(negedge clk);
        n = 1;
        check_output("ar_d0_en", 16'(dig_en_n), 16'hE);
        check_output("ar_d0_nib", 16'(digit_nib), 16'h0);
        step_to(4);
        check_output("ar_d1_blank", 16'(dig_en_n), 16'hF);
        step_to(5);
        check_output("ar_d1_en", 16'(dig_en_n), 16'hD);
        check_output("ar_d1_nib", 16'(digit_nib), 16'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

endmodule

// File: doc/display_scan.md
DISPLAY_SCAN -- requirements
Module: display_scan

Interface
REQ-001 Parameter CLK_DIV, default 50000, SHALL set the clock cycles each digit is displayed (legal range 2..2^20).
REQ-002 Parameter BLANK_CYC, default 500, SHALL set the anti-ghost blanking cycles at the start of each digit slot (legal range 0..CLK_DIV-1).
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  SHALL be the reset: asynchronous, active-low.
REQ-005 load  input  1  SHALL be the capture strobe for value; sampled on each rising edge.
REQ-006 value  input  16  SHALL carry four hex digits, digit 0 = value[3:0] through digit 3 = value[15:12].
REQ-007 blank_lz  input  1  SHALL enable leading-zero suppression when high.
REQ-008 digit_nib  output  4  SHALL carry the hex code of the selected digit, feeding the 7-segment decoder input.
REQ-009 dig_en_n  output  4  SHALL be the active-low digit enables, bit k = digit k.
REQ-010 frame_done  output  1  SHALL pulse high for one cycle per complete 4-digit scan.

Function
REQ-011 The shadow register SHALL load value on every rising edge with load=1; the displayed data SHALL come only from the shadow register.
REQ-012 A load during a scan SHALL NOT reset the prescaler or the digit index; the new data SHALL appear on digit_nib in the cycle after the capture edge.
REQ-013 The prescaler SHALL count 0..CLK_DIV-1 and wrap to 0; at the edge where it leaves CLK_DIV-1, the digit index SHALL advance 0->1->2->3->0.
REQ-014 frame_done SHALL be high exactly in the cycle after the index wraps 3->0 (prescaler=0, index=0), and low otherwise.
REQ-015 digit_nib SHALL equal shadow[4*idx+3:4*idx] as a combinational function of the registered idx and shadow, with no extra latency.
REQ-016 While prescaler<BLANK_CYC, dig_en_n SHALL be 4'b1111; otherwise exactly bit idx SHALL be 0, unless that digit is suppressed.
REQ-017 With blank_lz=1, digit k (k=3,2,1) SHALL be suppressed (dig_en_n all 1) when shadow digits k..3 are all zero; digit 0 SHALL never be suppressed.
REQ-018 With blank_lz=0, no digit SHALL be suppressed; blank_lz changes SHALL take effect in the same cycle, since the path is combinational.
REQ-019 With BLANK_CYC=0, there SHALL be no blanking interval.
REQ-020 dig_en_n SHALL never have more than one bit low in any cycle.
REQ-021 The prescaler width SHALL be $clog2(CLK_DIV); the terminal-count compare SHALL not overflow at CLK_DIV=2^20.

Reset
REQ-022 While rst_n=0, the following SHALL hold regardless of clk or load: shadow=16'h0000, prescaler=0, idx=0, digit_nib=4'h0, dig_en_n=4'b1111, frame_done=0.
REQ-023 An assertion of rst_n mid-slot or mid-load SHALL force the REQ-022 values immediately; the capture SHALL be discarded.
REQ-024 After rst_n deasserts, the first slot SHALL be digit 0, starting with a full BLANK_CYC blanking interval.

Verification (CLK_DIV=4, BLANK_CYC=1 unless stated)
REQ-025 Load value=16'h1A3F, blank_lz=0 -> per 4-cycle slot: digit_nib F,3,A,1; dig_en_n 1111 then 1110 x3, then 1111 then 1101 x3, and so on; frame_done 1 cycle every 16.
REQ-026 Load 16'h0050, blank_lz=1 -> digits 3 and 2 stay 1111 through their slots; digit 1 enabled with nib 5; digit 0 enabled with nib 0.
REQ-027 Load 16'h0000, blank_lz=1 -> only digit 0 is ever enabled (1110), with nib 0.
REQ-028 Load 16'h1111, then load 16'h2222 at prescaler=2 of the digit-1 slot -> next cycle nib=2, idx remains 1, slot length unchanged.
REQ-029 Assert rst_n=0 for 1 cycle at prescaler=3 of the digit-2 slot -> dig_en_n=1111, nib=0 asynchronously; after release, scan restarts at digit 0 and shadow=0.
REQ-030 CLK_DIV=2, BLANK_CYC=0 -> idx changes every 2 cycles; exactly one dig_en_n bit is low in every cycle.
